// File: rtl/cpu_mode_loader_pkg.sv
// Shared encodings for the front-panel mode loader and the control unit it feeds.
// RUN must stay 2'b11: the control unit decodes that value directly.
package cpu_mode_loader_pkg;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_IN    = 2'b01;
  localparam logic [1:0] ST_CHECK = 2'b10;
  localparam logic [1:0] ST_RUN   = 2'b11;

  // we/re are the one-cycle memory strobes; capt is the CHECK read-data capture cycle.
  typedef struct packed {
    logic we;
    logic re;
    logic capt;
  } op_t;

  function automatic logic is_loader_state(input logic [1:0] st);
    return (st == ST_IN) || (st == ST_CHECK);
  endfunction

endpackage

// File: rtl/cpu_mode_loader_key_debounce.sv
// Push-button conditioner: 2-flop sync, DEB_CYCLES stability filter, rising-level pulse.
// Latency: raw edge to key_pulse is 2 + DEB_CYCLES cycles; no backpressure (free-running).
module key_debounce #(
  parameter int DEB_CYCLES = 20000,
  parameter int CNT_W      = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic key_level,
  output logic key_pulse
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [1:0]       key_sync;
  logic [CNT_W-1:0] stable_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_sync   <= 2'b00;
      stable_cnt <= '0;
      key_level  <= 1'b0;
      key_pulse  <= 1'b0;
    end else begin
      key_sync  <= {key_sync[0], key_raw};
      key_pulse <= 1'b0;
      // Any cycle of agreement restarts the stability window.
      if (key_sync[1] != key_level) begin
        if (stable_cnt == CNT_LAST) begin
          key_level  <= key_sync[1];
          key_pulse  <= key_sync[1];
          stable_cnt <= '0;
        end else begin
          stable_cnt <= stable_cnt + 1'b1;
        end
      end else begin
        stable_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/cpu_mode_loader.sv
// Mode FSM and program loader: IN writes switch data, CHECK reads back, RUN hands memory to the CPU.
// Strobe one cycle after step_pulse; steps arriving while busy are dropped, mode changes wait for !busy.
module cpu_mode_loader
  import cpu_mode_loader_pkg::*;
#(
  parameter int AW         = 16,
  parameter int DW         = 8,
  parameter int DEB_CYCLES = 20000,
  parameter int CNT_W      = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    mode_sel,
  input  logic [AW-1:0] start_addr,
  input  logic [DW-1:0] data_sw,
  input  logic          key_step,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    cpustate,
  output logic          cpu_owns_mem,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  output logic          mem_re,
  output logic [DW-1:0] chk_data,
  output logic          chk_valid,
  output logic          addr_wrap
);

  logic [1:0] state;
  logic [1:0] mode_q;
  op_t        op;
  logic       key_level;
  logic       step_pulse;
  logic       busy;
  logic       step_go;
  logic       mode_go;

  key_debounce #(
    .DEB_CYCLES(DEB_CYCLES),
    .CNT_W     (CNT_W)
  ) u_key (
    .clk      (clk),
    .rst      (rst),
    .key_raw  (key_step),
    .key_level(key_level),
    .key_pulse(step_pulse)
  );

  assign busy    = op.we | op.re | op.capt;
  assign step_go = step_pulse && key_level && !busy && is_loader_state(state);
  // A step in the same cycle as a mode request wins; the mode change follows once busy clears.
  assign mode_go = (mode_q != state) && !busy && !step_go;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      mode_q    <= ST_IDLE;
      op        <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      chk_data  <= '0;
      chk_valid <= 1'b0;
      addr_wrap <= 1'b0;
    end else begin
      mode_q  <= mode_sel;
      op.we   <= step_go && (state == ST_IN);
      op.re   <= step_go && (state == ST_CHECK);
      op.capt <= op.re;

      if (step_go && (state == ST_IN)) begin
        mem_wdata <= data_sw;
      end

      if (op.capt) begin
        chk_data  <= mem_rdata;
        chk_valid <= 1'b1;
      end

      if (op.we || op.capt) begin
        mem_addr <= mem_addr + 1'b1;
        if (&mem_addr) begin
          addr_wrap <= 1'b1;
        end
      end

      if (mode_go) begin
        state <= mode_q;
        if (is_loader_state(mode_q)) begin
          mem_addr  <= start_addr;
          addr_wrap <= 1'b0;
          chk_valid <= 1'b0;
        end
      end
    end
  end

  assign cpustate     = state;
  assign cpu_owns_mem = (state == ST_RUN);
  assign mem_we       = op.we;
  assign mem_re       = op.re;

endmodule

// File: tb/tb_cpu_mode_loader.sv
// Randomized bench for cpu_mode_loader against an address/memory-level reference model.
module tb_cpu_mode_loader;
  import cpu_mode_loader_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  mode_sel = 2'b00;
  logic [15:0] start_addr = 16'h0000;
  logic [7:0]  data_sw = 8'h00;
  logic        key_step = 1'b0;
  logic [7:0]  mem_rdata = 8'h00;
  logic [1:0]  cpustate;
  logic        cpu_owns_mem;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [7:0]  chk_data;
  logic        chk_valid;
  logic        addr_wrap;

  int vectors = 0;
  int miscompares = 0;

  // Memory attached to the DUT port, and the model's own view of what was written.
  logic [7:0] ram [0:65535];
  logic [7:0] exp_mem [int];

  logic [1:0]  m_state = ST_IDLE;
  logic [15:0] m_addr = 16'h0000;
  logic        m_wrap = 1'b0;
  logic        m_valid = 1'b0;
  logic [7:0]  m_chk = 8'h00;

  cpu_mode_loader #(
    .AW(16), .DW(8), .DEB_CYCLES(4), .CNT_W(16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mode_sel    (mode_sel),
    .start_addr  (start_addr),
    .data_sw     (data_sw),
    .key_step    (key_step),
    .mem_rdata   (mem_rdata),
    .cpustate    (cpustate),
    .cpu_owns_mem(cpu_owns_mem),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_we      (mem_we),
    .mem_re      (mem_re),
    .chk_data    (chk_data),
    .chk_valid   (chk_valid),
    .addr_wrap   (addr_wrap)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= ram[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_rd(input logic [15:0] a);
    return exp_mem.exists(int'(a)) ? exp_mem[int'(a)] : 8'h00;
  endfunction

  task automatic advance_addr();
    if (m_addr == 16'hFFFF) m_wrap = 1'b1;
    m_addr = m_addr + 16'h0001;
  endtask

  task automatic set_mode(input logic [1:0] m, input logic [15:0] sa);
    @(posedge clk); #1;
    mode_sel = m;
    start_addr = sa;
    repeat (3) @(posedge clk);
    @(negedge clk);
    if (m != m_state) begin
      m_state = m;
      if (m == ST_IN || m == ST_CHECK) begin
        m_addr = sa;
        m_wrap = 1'b0;
        m_valid = 1'b0;
      end
    end
    check("mode_state", cpustate, m_state);
    check("mode_owns", cpu_owns_mem, m_state == ST_RUN);
    check("mode_addr", mem_addr, m_addr);
    check("mode_wrap", addr_wrap, m_wrap);
    check("mode_valid", chk_valid, m_valid);
  endtask

  task automatic glitch(input int n);
    int pulses = 0;
    int strobes = 0;
    @(posedge clk); #1;
    key_step = 1'b1;
    repeat (n) @(posedge clk);
    #1 key_step = 1'b0;
    repeat (10) begin
      @(posedge clk); @(negedge clk);
      if (dut.u_key.key_pulse) pulses++;
      if (mem_we || mem_re) strobes++;
    end
    check("glitch_pulse", pulses, 0);
    check("glitch_strobe", strobes, 0);
  endtask

  task automatic press(input logic [7:0] d);
    int lat = -1;
    int pulses = 0;
    int we_n = 0;
    int re_n = 0;
    logic [15:0] w_addr = 16'h0000;
    logic [7:0]  w_dat = 8'h00;
    @(posedge clk); #1;
    key_step = 1'b1;
    data_sw = d;
    for (int c = 1; c <= 24; c++) begin
      @(posedge clk); @(negedge clk);
      if (c == 12) key_step = 1'b0;
      if (dut.u_key.key_pulse) begin
        pulses++;
        if (lat < 0) lat = c;
      end
      if (mem_we) begin
        we_n++;
        w_addr = mem_addr;
        w_dat = mem_wdata;
      end
      if (mem_re) re_n++;
    end
    check("step_latency", lat, 6);
    check("step_pulses", pulses, 1);
    if (m_state == ST_IN) begin
      check("in_we_cycles", we_n, 1);
      check("in_re_cycles", re_n, 0);
      check("in_waddr", w_addr, m_addr);
      check("in_wdata", w_dat, d);
      exp_mem[int'(m_addr)] = d;
      advance_addr();
    end else if (m_state == ST_CHECK) begin
      check("chk_re_cycles", re_n, 1);
      check("chk_we_cycles", we_n, 0);
      m_chk = exp_rd(m_addr);
      m_valid = 1'b1;
      advance_addr();
      check("chk_data", chk_data, m_chk);
    end else begin
      check("idle_run_strobes", we_n + re_n, 0);
    end
    check("press_addr", mem_addr, m_addr);
    check("press_wrap", addr_wrap, m_wrap);
    check("press_valid", chk_valid, m_valid);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1);
  end

  initial begin
    logic found;
    for (int i = 0; i < 65536; i++) ram[i] = 8'h00;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_state", cpustate, ST_IDLE);
    check("rst_owns", cpu_owns_mem, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_strobes", {mem_we, mem_re}, 0);
    check("rst_chk", {chk_valid, chk_data}, 0);
    check("rst_wrap", addr_wrap, 0);
    @(posedge clk); #1 rst = 1'b0;

    press(8'h11);

    set_mode(ST_IN, 16'h0010);
    glitch(3);
    press(8'hA5);
    press(8'h3C);
    check("in_end_addr", mem_addr, 16'h0012);

    set_mode(ST_CHECK, 16'h0010);
    press(8'h00);
    check("chk_first", chk_data, 8'hA5);
    press(8'h00);
    check("chk_second", chk_data, 8'h3C);
    check("chk_end_addr", mem_addr, 16'h0012);

    set_mode(ST_IN, 16'hFFFF);
    press(8'h5A);
    check("wrap_addr", mem_addr, 16'h0000);
    check("wrap_flag", addr_wrap, 1);
    set_mode(ST_CHECK, 16'h0010);
    check("wrap_cleared", addr_wrap, 0);

    // Request RUN while a CHECK read is in flight: capture must land before handoff.
    @(posedge clk); #1 key_step = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(posedge clk); @(negedge clk);
      if (mem_re) begin
        found = 1'b1;
        mode_sel = ST_RUN;
        @(posedge clk); @(negedge clk);
        check("handoff_hold1", cpustate, ST_CHECK);
        @(posedge clk); @(negedge clk);
        check("handoff_hold2", cpustate, ST_CHECK);
        check("handoff_valid", chk_valid, 1);
        check("handoff_data", chk_data, exp_rd(16'h0010));
        @(posedge clk); @(negedge clk);
        check("handoff_run", cpustate, ST_RUN);
        check("handoff_owns", cpu_owns_mem, 1);
        check("handoff_addr", mem_addr, 16'h0011);
      end
    end
    check("handoff_strobe_seen", found, 1);
    key_step = 1'b0;
    repeat (12) @(posedge clk);
    m_state = ST_RUN;
    m_addr = 16'h0011;
    m_valid = 1'b1;
    press(8'h77);

    for (int it = 0; it < 30; it++) begin
      logic [1:0]  m;
      logic [15:0] sa;
      int          n;
      m = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) sa = 16'(16'hFFFE + $urandom_range(0, 1));
      else sa = 16'(16'h00F0 + $urandom_range(0, 31));
      set_mode(m, sa);
      if ($urandom_range(0, 2) == 0) glitch(int'($urandom_range(1, 3)));
      n = int'($urandom_range(1, 3));
      for (int k = 0; k < n; k++) press(8'($urandom));
    end

    // Async reset in the middle of an IN write strobe.
    set_mode(ST_IN, 16'h0040);
    @(posedge clk); #1 key_step = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (mem_we) begin
        found = 1'b1;
        rst = 1'b1;
        #1;
        check("midrst_we", mem_we, 0);
        check("midrst_state", cpustate, ST_IDLE);
        check("midrst_addr", mem_addr, 0);
        check("midrst_wdata", mem_wdata, 0);
        check("midrst_flags", {chk_valid, addr_wrap, cpu_owns_mem, mem_re}, 0);
      end
    end
    check("midrst_strobe_seen", found, 1);
    key_step = 1'b0;
    mode_sel = ST_IDLE;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("post_rst_state", cpustate, ST_IDLE);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cpu_mode_loader.md
Name: cpu_mode_loader

Overview:
- Front-panel mode controller and program loader sitting directly upstream of the instruction control unit.
- Generates the 2-bit CPUstate (IDLE/IN/CHECK/RUN) that the control unit consumes; the control unit runs only while CPUstate = RUN.
- In IN mode it writes switch data into program memory word by word. In CHECK mode it reads memory back for display.
- Owns the memory port except in RUN, when it hands ownership to the CPU.

Parameters:
- AW, 16, memory address width.
- DW, 8, memory data width.
- DEB_CYCLES, 20000, consecutive stable cycles required to accept a key level change.
- CNT_W, 16, width of the debounce counters; must hold DEB_CYCLES.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- mode_sel  in  2  requested mode from switches: 00 IDLE, 01 IN, 10 CHECK, 11 RUN.
- start_addr  in  AW  address loaded when entering IN or CHECK.
- data_sw  in  DW  data switches used for IN writes.
- key_step  in  1  raw, asynchronous push-button: write in IN, read in CHECK.
- mem_rdata  in  DW  memory read data, valid 1 cycle after mem_re.
- cpustate  out  2  current state: 00 IDLE, 01 IN, 10 CHECK, 11 RUN.
- cpu_owns_mem  out  1  1 when state = RUN; selects CPU addr/data at the memory mux.
- mem_addr  out  AW  loader address.
- mem_wdata  out  DW  loader write data.
- mem_we  out  1  1-cycle write strobe.
- mem_re  out  1  1-cycle read strobe.
- chk_data  out  DW  last data read back in CHECK.
- chk_valid  out  1  chk_data holds a read made in the current CHECK session.
- addr_wrap  out  1  sticky flag; address wrapped from 2^AW-1 to 0 in this session.

Behaviour:
- Reset (async, rst=1): state IDLE; cpustate=00; cpu_owns_mem=0; mem_addr=0; mem_wdata=0; mem_we=0; mem_re=0; chk_data=0; chk_valid=0; addr_wrap=0; debounce state = released; counters=0.
- Key path:
  - key_step passes through a 2-flop synchronizer.
  - The debounced level toggles only after the synchronized input has differed from it for DEB_CYCLES consecutive cycles. The counter clears on any agreement.
  - step_pulse is high for exactly 1 cycle on each debounced 0->1 transition.
  - Latency from a clean raw edge to step_pulse is 2 + DEB_CYCLES cycles.
- Sub-state busy covers the cycle of a strobe and, in CHECK, the capture cycle that follows it.
- Mode FSM:
  - mode_sel is registered once (mode_q). A transition occurs when mode_q differs from state and busy=0.
  - If busy, the transition waits until busy clears.
  - Entering IN or CHECK: mem_addr<=start_addr, addr_wrap<=0, chk_valid<=0.
  - Entering RUN: cpustate and cpu_owns_mem become 11/1 in the same cycle as the state change. mem_we and mem_re are forced 0 throughout RUN.
  - Leaving RUN: cpustate changes in the transition cycle; mem_addr is unchanged.
  - IDLE and RUN ignore step_pulse.
- IN write:
  - On step_pulse, the next cycle drives mem_we=1, mem_wdata=data_sw (sampled in the pulse cycle), mem_addr=current address.
  - In the cycle after the strobe, mem_addr increments by 1.
- CHECK read:
  - On step_pulse, the next cycle drives mem_re=1.
  - The following cycle captures chk_data<=mem_rdata, sets chk_valid=1 and increments mem_addr.
- Wrap: incrementing from 2^AW-1 yields 0 and sets addr_wrap (sticky until the next IN/CHECK entry or reset).
- step_pulse while busy is dropped; no queueing.
- A mode change requested in the same cycle as step_pulse: the step is serviced first, and the mode change is taken after busy clears.
- Reset mid-operation: all activity aborts immediately. No strobe may remain asserted.

Decomposition:
- Shared package: state encodings ST_IDLE=2'b00, ST_IN=2'b01, ST_CHECK=2'b10, ST_RUN=2'b11. These must match the RUN = 2'b11 value the control unit decodes.
- One sub-module, key_debounce: synchronizer, debounce counter and pulse generator. Parameters DEB_CYCLES and CNT_W. Ports clk, rst, key_raw, key_level, key_pulse.

Test Plan:
- Reset behaviour: assert rst mid-IN-write with mem_we=1 -> mem_we=0 the same cycle; all outputs at reset values; cpustate=00.
- Debounce (DEB_CYCLES=4): 3-cycle glitch on key_step -> no step_pulse. Clean press -> exactly one step_pulse, 6 cycles after the raw edge.
- IN write sequence: mode_sel=01, start_addr=0x0010, data_sw=0xA5 then 0x3C on two presses -> writes 0x10<-A5 and 0x11<-3C; mem_addr=0x0012; single-cycle mem_we each time.
- CHECK read: mode_sel=10, start_addr=0x0010, two presses against a memory model -> chk_data=A5 then 3C; chk_valid=1; mem_addr=0x0012.
- Wrap: start_addr=0xFFFF in IN, one press -> write at 0xFFFF; mem_addr=0x0000; addr_wrap=1. Re-entering CHECK clears addr_wrap.
- RUN handoff: switch to 11 during a pending CHECK read -> capture completes first, then cpustate=11 and cpu_owns_mem=1. Key presses in RUN produce no strobes.
